dm_lsu: RTL and testbench

Parametrised load/store unit between the MEM/WB stages and the data bus. It replaces the purely combinational data-memory interface with a valid/ready request channel and a response channel. A pending-load queue carries each load's byte offset and funct3 to the response, so alignment and extension use the load's own address rather than the WB-stage pipeline. It also adds misalignment exceptions, XLEN=64 support and multiple outstanding loads.

---
 rtl/rv_pkg.sv | 34 +++
 rtl/dm_lsu_if.sv | 45 ++++
 rtl/dm_pending_fifo.sv | 67 ++++++
 rtl/dm_lsu.sv | 133 +++++++++++++
 tb/tb_dm_lsu.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared RV load/store definitions: funct3 codes, access-size decode and
// the pending-load queue entry.
package rv_pkg;

  localparam logic [2:0] FUNCT3_BYTE       = 3'b000;
  localparam logic [2:0] FUNCT3_HALFWORD   = 3'b001;
  localparam logic [2:0] FUNCT3_WORD       = 3'b010;
  localparam logic [2:0] FUNCT3_DOUBLE     = 3'b011;
  localparam logic [2:0] FUNCT3_BYTE_U     = 3'b100;
  localparam logic [2:0] FUNCT3_HALFWORD_U = 3'b101;
  localparam logic [2:0] FUNCT3_WORD_U     = 3'b110;

  // Offset is sized for the widest datapath (XLEN=64); narrower units leave bit 2 zero.
  typedef struct packed {
    logic [2:0] offset;
    logic [2:0] funct3;
  } pend_t;

  // Access size in bytes; 0 marks a funct3 that is illegal for this XLEN.
  function automatic logic [3:0] size_decode(input logic [2:0] funct3, input logic xlen64);
    logic [3:0] sz;
    sz = 4'd0;
    case (funct3)
      FUNCT3_BYTE, FUNCT3_BYTE_U:         sz = 4'd1;
      FUNCT3_HALFWORD, FUNCT3_HALFWORD_U: sz = 4'd2;
      FUNCT3_WORD:                        sz = 4'd4;
      FUNCT3_WORD_U:                      sz = xlen64 ? 4'd4 : 4'd0;
      FUNCT3_DOUBLE:                      sz = xlen64 ? 4'd8 : 4'd0;
      default:                            sz = 4'd0;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/dm_lsu_if.sv
// Request, response, exception and data-bus signals of the load/store unit.
// slave = the LSU itself, master = the pipeline plus memory driving it.
interface dm_lsu_if #(
  parameter int XLEN = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_load;
  logic              req_store;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [2:0]        req_funct3;

  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_data;

  logic              exc_valid;
  logic              exc_store;
  logic [XLEN-1:0]   exc_addr;

  logic              bus_valid;
  logic              bus_ready;
  logic              bus_we;
  logic [XLEN-1:0]   bus_addr;
  logic [XLEN-1:0]   bus_wdata;
  logic [XLEN/8-1:0] bus_wmask;
  logic              bus_rvalid;
  logic [XLEN-1:0]   bus_rdata;

  logic              proto_err;

  modport slave (
    input  req_valid, req_load, req_store, req_addr, req_wdata, req_funct3,
    input  bus_ready, bus_rvalid, bus_rdata,
    output req_ready, rsp_valid, rsp_data, exc_valid, exc_store, exc_addr,
    output bus_valid, bus_we, bus_addr, bus_wdata, bus_wmask, proto_err
  );

  modport master (
    output req_valid, req_load, req_store, req_addr, req_wdata, req_funct3,
    output bus_ready, bus_rvalid, bus_rdata,
    input  req_ready, rsp_valid, rsp_data, exc_valid, exc_store, exc_addr,
    input  bus_valid, bus_we, bus_addr, bus_wdata, bus_wmask, proto_err
  );
endinterface

// File: rtl/dm_pending_fifo.sv
// Synchronous FIFO for in-flight loads. Head data is combinational so the
// response path can align in the same cycle the data returns.
module dm_pending_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW       = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);

  // Pointer wrap and occupancy update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer/count state; reset discards any queued entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read while counted.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/dm_lsu.sv
// Load/store unit: combinational request path onto the data bus, misalignment
// exceptions, and a pending-load queue that lets each response be aligned and
// extended with its own load's offset and funct3.
module dm_lsu
  import rv_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic    clk,
  input  logic    rst,
  dm_lsu_if.slave io
);
  localparam int   NB   = XLEN / 8;
  localparam int   OW   = $clog2(NB);
  localparam logic IS64 = (XLEN == 64);

  logic [OW-1:0]   offset;
  logic [3:0]      size;
  logic            misal;
  logic [NB-1:0]   size_mask;
  logic            full, empty, push, pop;
  pend_t           push_ent, head;
  logic [XLEN-1:0] shifted, ext;

  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_data_q,  rsp_data_d;
  logic            exc_valid_q, exc_valid_d;
  logic            exc_store_q, exc_store_d;
  logic [XLEN-1:0] exc_addr_q,  exc_addr_d;
  logic            proto_err_q, proto_err_d;

  assign offset    = io.req_addr[OW-1:0];
  assign size      = size_decode(io.req_funct3, IS64);
  // Illegal funct3 decodes to size 0 and is treated exactly like a misaligned access.
  assign misal     = (size == 4'd0) || ((4'(offset) & (size - 4'd1)) != 4'd0);
  // Wraps to all-ones when size equals the bus width in bytes.
  assign size_mask = (NB'(1) << size) - NB'(1);

  assign pop  = io.bus_rvalid && !empty;
  assign push = io.req_valid && io.req_load && !misal && io.req_ready;

  assign push_ent.offset = 3'(offset);
  assign push_ent.funct3 = io.req_funct3;

  // Request path: misaligned requests are swallowed here and never reach the bus.
  always_comb begin
    io.bus_valid = io.req_valid && !misal;
    io.bus_we    = io.req_store;
    io.bus_addr  = io.req_addr;
    io.bus_wdata = io.req_wdata << {offset, 3'b000};
    io.bus_wmask = '0;
    io.req_ready = 1'b1;
    if (!misal) begin
      if (io.req_store) begin
        io.bus_wmask = size_mask << offset;
        io.req_ready = io.bus_ready;
      end else begin
        io.req_ready = io.bus_ready && (!full || pop);
      end
    end
  end

  dm_pending_fifo #(
    .WIDTH ($bits(pend_t)),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pend (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (push_ent),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // Response alignment and extension from the head entry; W on XLEN=32 sign-casts to itself.
  always_comb begin
    shifted = io.bus_rdata >> {head.offset, 3'b000};
    ext     = shifted;
    case (head.funct3)
      FUNCT3_BYTE:       ext = XLEN'($signed(shifted[7:0]));
      FUNCT3_BYTE_U:     ext = XLEN'(shifted[7:0]);
      FUNCT3_HALFWORD:   ext = XLEN'($signed(shifted[15:0]));
      FUNCT3_HALFWORD_U: ext = XLEN'(shifted[15:0]);
      FUNCT3_WORD:       ext = XLEN'($signed(shifted[31:0]));
      FUNCT3_WORD_U:     ext = XLEN'(shifted[31:0]);
      default:           ext = shifted;
    endcase
  end

  // Next state of the response, exception and protocol-error registers.
  always_comb begin
    rsp_valid_d = pop;
    rsp_data_d  = pop ? ext : rsp_data_q;
    exc_valid_d = io.req_valid && misal;
    exc_store_d = exc_store_q;
    exc_addr_d  = exc_addr_q;
    if (exc_valid_d) begin
      exc_store_d = io.req_store;
      exc_addr_d  = io.req_addr;
    end
    proto_err_d = proto_err_q || (io.bus_rvalid && empty);
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      exc_valid_q <= 1'b0;
      exc_store_q <= 1'b0;
      exc_addr_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      exc_valid_q <= exc_valid_d;
      exc_store_q <= exc_store_d;
      exc_addr_q  <= exc_addr_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign io.rsp_valid = rsp_valid_q;
  assign io.rsp_data  = rsp_data_q;
  assign io.exc_valid = exc_valid_q;
  assign io.exc_store = exc_store_q;
  assign io.exc_addr  = exc_addr_q;
  assign io.proto_err = proto_err_q;

endmodule

// File: tb/tb_dm_lsu.sv
// Bench for dm_lsu: an XLEN=32 and an XLEN=64 unit share the same stimulus,
// each tracked by its own queue-based reference model.
module tb_dm_lsu;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dm_lsu_if #(.XLEN(32)) if32 ();
  dm_lsu_if #(.XLEN(64)) if64 ();

  dm_lsu #(.XLEN(32), .MAX_OUTSTANDING(DEPTH)) u_dut32 (.clk(clk), .rst(rst), .io(if32.slave));
  dm_lsu #(.XLEN(64), .MAX_OUTSTANDING(DEPTH)) u_dut64 (.clk(clk), .rst(rst), .io(if64.slave));

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // stimulus
  logic        s_valid, s_load, s_store, s_bready, s_rvalid;
  logic [63:0] s_addr, s_wdata, s_rdata;
  logic [2:0]  s_f3;

  // reference model
  typedef struct { int off; int f3; } ent_t;
  ent_t        mq0[$];
  ent_t        mq1[$];
  logic        m_rsp_valid[2], m_exc_valid[2], m_exc_store[2], m_proto[2];
  logic [63:0] m_rsp_data[2], m_exc_addr[2];

  // combinational samples from the last step
  logic        c_ready[2], c_bvalid[2];
  logic [63:0] c_wdata[2], c_wmask[2];

  function automatic int msize(input int f3, input bit is64);
    case (f3)
      0, 4:    return 1;
      1, 5:    return 2;
      2:       return 4;
      6:       return is64 ? 4 : 0;
      3:       return is64 ? 8 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic int qlen(input int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic string tg(input int k, input string s);
    return $sformatf("x%0d %s", (k == 0) ? 32 : 64, s);
  endfunction

  task automatic model_clear();
    mq0.delete();
    mq1.delete();
    for (int k = 0; k < 2; k++) begin
      m_rsp_valid[k] = 0; m_rsp_data[k] = 0; m_exc_valid[k] = 0;
      m_exc_store[k] = 0; m_exc_addr[k] = 0; m_proto[k] = 0;
    end
  endtask

  task automatic apply();
    if32.req_valid = s_valid;   if64.req_valid = s_valid;
    if32.req_load  = s_load;    if64.req_load  = s_load;
    if32.req_store = s_store;   if64.req_store = s_store;
    if32.req_addr  = s_addr[31:0];  if64.req_addr  = s_addr;
    if32.req_wdata = s_wdata[31:0]; if64.req_wdata = s_wdata;
    if32.req_funct3 = s_f3;     if64.req_funct3 = s_f3;
    if32.bus_ready = s_bready;  if64.bus_ready = s_bready;
    if32.bus_rvalid = s_rvalid; if64.bus_rvalid = s_rvalid;
    if32.bus_rdata = s_rdata[31:0]; if64.bus_rdata = s_rdata;
  endtask

  task automatic check_regs();
    chk(tg(0, "rsp_valid"), 64'(if32.rsp_valid), 64'(m_rsp_valid[0]));
    chk(tg(0, "rsp_data"),  64'(if32.rsp_data),  m_rsp_data[0]);
    chk(tg(0, "exc_valid"), 64'(if32.exc_valid), 64'(m_exc_valid[0]));
    chk(tg(0, "exc_store"), 64'(if32.exc_store), 64'(m_exc_store[0]));
    chk(tg(0, "exc_addr"),  64'(if32.exc_addr),  m_exc_addr[0]);
    chk(tg(0, "proto_err"), 64'(if32.proto_err), 64'(m_proto[0]));
    chk(tg(1, "rsp_valid"), 64'(if64.rsp_valid), 64'(m_rsp_valid[1]));
    chk(tg(1, "rsp_data"),  if64.rsp_data,       m_rsp_data[1]);
    chk(tg(1, "exc_valid"), 64'(if64.exc_valid), 64'(m_exc_valid[1]));
    chk(tg(1, "exc_store"), 64'(if64.exc_store), 64'(m_exc_store[1]));
    chk(tg(1, "exc_addr"),  if64.exc_addr,       m_exc_addr[1]);
    chk(tg(1, "proto_err"), 64'(if64.proto_err), 64'(m_proto[1]));
  endtask

  // One clock: drive, check request path mid-cycle, advance model, check registers.
  task automatic step();
    logic [63:0] xm, sh, v, lim, emask;
    int xb, off, sz, n;
    bit mis, pop, rdy, sgn;
    ent_t e;
    apply();
    @(negedge clk);
    c_ready[0] = if32.req_ready;  c_bvalid[0] = if32.bus_valid;
    c_wdata[0] = 64'(if32.bus_wdata); c_wmask[0] = 64'(if32.bus_wmask);
    c_ready[1] = if64.req_ready;  c_bvalid[1] = if64.bus_valid;
    c_wdata[1] = if64.bus_wdata;  c_wmask[1] = 64'(if64.bus_wmask);
    for (int k = 0; k < 2; k++) begin
      xb  = (k == 0) ? 4 : 8;
      xm  = (k == 0) ? 64'hFFFF_FFFF : '1;
      off = int'(s_addr[2:0]) % xb;
      sz  = msize(int'(s_f3), k == 1);
      mis = (sz == 0);
      if (!mis) mis = (off % sz) != 0;
      pop = s_rvalid && (qlen(k) > 0);
      rdy = 1'b0;
      if (s_valid && mis) begin
        chk(tg(k, "ready(mis)"), 64'(c_ready[k]), 64'd1);
        chk(tg(k, "bus_valid(mis)"), 64'(c_bvalid[k]), 64'd0);
      end else if (s_valid) begin
        rdy = s_store ? s_bready : (s_bready && (qlen(k) < DEPTH || pop));
        chk(tg(k, "ready"), 64'(c_ready[k]), 64'(rdy));
        chk(tg(k, "bus_valid"), 64'(c_bvalid[k]), 64'd1);
        emask = s_store ? (((64'd1 << sz) - 64'd1) << off) : 64'd0;
        chk(tg(k, "wmask"), c_wmask[k], emask);
        if (s_store) chk(tg(k, "wdata"), c_wdata[k], (s_wdata << (8 * off)) & xm);
      end else begin
        chk(tg(k, "bus_valid(idle)"), 64'(c_bvalid[k]), 64'd0);
      end
      // next-state of the model
      m_proto[k]     = m_proto[k] || (s_rvalid && qlen(k) == 0);
      m_rsp_valid[k] = pop;
      if (pop) begin
        e = (k == 0) ? mq0.pop_front() : mq1.pop_front();
        sh = (s_rdata & xm) >> (8 * e.off);
        case (e.f3)
          0: begin n = 1; sgn = 1; end
          4: begin n = 1; sgn = 0; end
          1: begin n = 2; sgn = 1; end
          5: begin n = 2; sgn = 0; end
          2: begin n = 4; sgn = 1; end
          6: begin n = 4; sgn = 0; end
          default: begin n = 8; sgn = 0; end
        endcase
        v = sh;
        if (n < 8) begin
          lim = (64'd1 << (8 * n)) - 64'd1;
          v = sh & lim;
          if (sgn && v[8*n-1]) v = v | ~lim;
        end
        m_rsp_data[k] = v & xm;
      end
      m_exc_valid[k] = s_valid && mis;
      if (s_valid && mis) begin
        m_exc_store[k] = s_store;
        m_exc_addr[k]  = s_addr & xm;
      end
      if (s_valid && !mis && s_load && rdy) begin
        e.off = off; e.f3 = int'(s_f3);
        if (k == 0) mq0.push_back(e); else mq1.push_back(e);
      end
    end
    @(posedge clk); #1;
    check_regs();
  endtask

  task automatic cyc(input bit v, input bit ld, input logic [63:0] a, input logic [63:0] wd,
                     input logic [2:0] f3, input bit br, input bit rv, input logic [63:0] rd);
    s_valid = v; s_load = v && ld; s_store = v && !ld;
    s_addr = a; s_wdata = wd; s_f3 = f3; s_bready = br; s_rvalid = rv; s_rdata = rd;
    step();
  endtask

  task automatic idle(input bit rv, input logic [63:0] rd);
    cyc(0, 0, 64'd0, 64'd0, 3'd0, 1'b1, rv, rd);
  endtask

  task automatic do_reset();
    s_valid = 0; s_load = 0; s_store = 0; s_addr = 0; s_wdata = 0; s_f3 = 0;
    s_bready = 1; s_rvalid = 0; s_rdata = 0;
    apply();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    check_regs();
  endtask

  initial begin
    do_reset();

    // LB / LBU at 0x1003, data one cycle later
    cyc(1, 1, 64'h1003, 0, 3'd0, 1, 0, 0);
    idle(1, 64'h80FF_FFFF);
    chk("lb rsp_valid", 64'(if32.rsp_valid), 64'd1);
    chk("lb rsp_data", 64'(if32.rsp_data), 64'h0000_0000_FFFF_FF80);
    cyc(1, 1, 64'h1003, 0, 3'd4, 1, 0, 0);
    idle(1, 64'h80FF_FFFF);
    chk("lbu rsp_data", 64'(if32.rsp_data), 64'h0000_0080);
    idle(0, 0);

    // SH at 0x2002
    cyc(1, 0, 64'h2002, 64'h0000_BEEF, 3'd1, 1, 0, 0);
    chk("sh wmask", c_wmask[0], 64'hC);
    chk("sh wdata", c_wdata[0], 64'hBEEF_0000);
    chk("sh no rsp", 64'(if32.rsp_valid), 64'd0);

    // misaligned LW
    cyc(1, 1, 64'h3001, 0, 3'd2, 1, 0, 0);
    chk("lw mis bus_valid", 64'(c_bvalid[0]), 64'd0);
    chk("lw mis ready", 64'(c_ready[0]), 64'd1);
    chk("lw mis exc_valid", 64'(if32.exc_valid), 64'd1);
    chk("lw mis exc_addr", 64'(if32.exc_addr), 64'h3001);
    chk("lw mis exc_store", 64'(if32.exc_store), 64'd0);
    idle(0, 0);
    chk("exc pulse", 64'(if32.exc_valid), 64'd0);

    // queue full stall, then push+pop at full
    cyc(1, 1, 64'h4000, 0, 3'd2, 1, 0, 0);
    cyc(1, 1, 64'h4004, 0, 3'd2, 1, 0, 0);
    cyc(1, 1, 64'h4008, 0, 3'd2, 1, 0, 0);
    chk("3rd load stalls", 64'(c_ready[0]), 64'd0);
    cyc(1, 1, 64'h4008, 0, 3'd2, 1, 1, 64'h1111_2222);
    chk("push+pop at full", 64'(c_ready[0]), 64'd1);
    cyc(1, 1, 64'h400C, 0, 3'd2, 1, 0, 0);
    chk("count stays full", 64'(c_ready[0]), 64'd0);
    idle(1, 64'h3333_4444);
    idle(1, 64'h5555_6666);
    idle(0, 0);

    // XLEN=64 LWU at offset 4, LD at offset 4
    cyc(1, 1, 64'h5004, 0, 3'd6, 1, 0, 0);
    idle(1, 64'h8765_4321_DEAD_BEEF);
    chk("lwu64 rsp_data", if64.rsp_data, 64'h0000_0000_8765_4321);
    cyc(1, 1, 64'h5004, 0, 3'd3, 1, 0, 0);
    chk("ld64 mis exc", 64'(if64.exc_valid), 64'd1);

    // protocol error after reset, sticky
    do_reset();
    idle(1, 64'h1234);
    chk("proto set", 64'(if32.proto_err), 64'd1);
    chk("proto no rsp", 64'(if32.rsp_valid), 64'd0);
    idle(0, 0);
    idle(0, 0);
    chk("proto sticky", 64'(if64.proto_err), 64'd1);

    // mid-load reset, late rvalid
    do_reset();
    cyc(1, 1, 64'h6000, 0, 3'd2, 1, 0, 0);
    do_reset();
    idle(1, 64'hABCD);
    chk("late rvalid proto32", 64'(if32.proto_err), 64'd1);
    chk("late rvalid proto64", 64'(if64.proto_err), 64'd1);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      s_valid  = ($urandom_range(0, 9) < 7);
      s_load   = s_valid && $urandom_range(0, 1) == 1;
      s_store  = s_valid && !s_load;
      s_addr   = {32'd0, 16'h0, 16'($urandom)};
      s_wdata  = {$urandom, $urandom};
      s_f3     = 3'($urandom_range(0, 7));
      s_bready = ($urandom_range(0, 3) != 0);
      s_rvalid = ($urandom_range(0, 9) < 4);
      s_rdata  = {$urandom, $urandom};
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
